// File: rtl/feature_tensor_buffer.sv
// feature_tensor_buffer: assembles serialized node features into a tensor and streams it out
module feature_tensor_buffer #(
  parameter int GRAPH_SIZE = 4,
  parameter int PRECISION  = 16,
  parameter int INPUT_DIM  = 64,
  parameter int ADDR_WIDTH = $clog2(GRAPH_SIZE**3),
  parameter int MEM_AW     = ADDR_WIDTH + $clog2(INPUT_DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [PRECISION-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  slice_done,
  output logic                  frame_ready,
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic [PRECISION-1:0]  rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  err_overrun
);
  localparam int CW    = $clog2(INPUT_DIM);
  localparam int CCW   = CW + 1;
  localparam int NODES = GRAPH_SIZE * GRAPH_SIZE;
  localparam int NW    = $clog2(NODES);
  localparam int SW    = $clog2(GRAPH_SIZE) + 1;
  localparam int DEPTH = GRAPH_SIZE**3 * INPUT_DIM;
  localparam int PW    = MEM_AW + 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [CW:0]           ch_q, ch_d;
  logic [NW-1:0]         node_q, node_d;
  logic [SW-1:0]         slices_q, slices_d;
  logic                  sd_q, sd_d;
  logic                  err_q, err_d;
  logic                  same, drop, we, node_done, wrap;
  logic [CW-1:0]         ch_idx;
  logic [PRECISION-1:0]  mem_q [DEPTH];

  state_t                state_q;
  logic [PW-1:0]         ptr_q;
  logic [1:0]            cnt_q;
  logic                  h_q;
  logic [PRECISION-1:0]  fd_q [2];
  logic [1:0]            fl_q;
  logic                  issue, pop, wslot;

  // channel tracking, node/slice counting and next-state for the write side
  always_comb begin
    same      = !first_q && in_addr == last_q;
    drop      = same && ch_q == CCW'(INPUT_DIM);
    we        = in_valid && !drop;
    ch_idx    = same ? ch_q[CW-1:0] : '0;
    node_done = we && ch_idx == CW'(INPUT_DIM - 1);
    wrap      = node_done && node_q == NW'(NODES - 1);
    first_d   = first_q && !in_valid;
    last_d    = in_valid ? in_addr : last_q;
    ch_d      = !in_valid ? ch_q : !same ? CCW'(1) : drop ? ch_q : ch_q + 1'b1;
    node_d    = wrap ? '0 : node_done ? node_q + 1'b1 : node_q;
    slices_d  = wrap && slices_q != SW'(GRAPH_SIZE) ? slices_q + 1'b1 : slices_q;
    sd_d      = wrap;
    err_d     = err_q || (in_valid && drop);
  end

  // write-side state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q  <= 1'b1;
      last_q   <= '0;
      ch_q     <= '0;
      node_q   <= '0;
      slices_q <= '0;
      sd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      first_q  <= first_d;
      last_q   <= last_d;
      ch_q     <= ch_d;
      node_q   <= node_d;
      slices_q <= slices_d;
      sd_q     <= sd_d;
      err_q    <= err_d;
    end
  end

  // tensor memory write port; address is {node, channel} since INPUT_DIM is a power of two
  always_ff @(posedge clk) begin
    if (we) mem_q[{in_addr, ch_idx}] <= in_data;
  end

  // read issue when FIFO has room, pop on handshake; slot to fill follows the head
  always_comb begin
    issue = (state_q == FILL || state_q == STREAM) && cnt_q != 2'd2 && ptr_q != PW'(DEPTH);
    pop   = rd_valid && rd_ready;
    wslot = h_q ^ cnt_q[0];
  end

  // readout FSM; the registered memory read lands directly in a FIFO slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      h_q     <= 1'b0;
      fd_q[0] <= '0;
      fd_q[1] <= '0;
      fl_q    <= '0;
    end else begin
      if (issue) begin
        fd_q[wslot] <= mem_q[ptr_q[MEM_AW-1:0]];
        fl_q[wslot] <= ptr_q == PW'(DEPTH - 1);
        ptr_q       <= ptr_q + 1'b1;
      end
      if (pop) h_q <= !h_q;
      cnt_q <= cnt_q + {1'b0, issue} - {1'b0, pop};
      if (state_q == IDLE && rd_start && frame_ready) begin
        state_q <= FILL;
        ptr_q   <= '0;
      end else if (issue && ptr_q == PW'(DEPTH - 1)) state_q <= DRAIN;
      else if (state_q == FILL && cnt_q != 2'd0) state_q <= STREAM;
      else if (state_q == DRAIN && pop && rd_last) state_q <= IDLE;
    end
  end

  assign slice_done  = sd_q;
  assign err_overrun = err_q;
  assign frame_ready = slices_q == SW'(GRAPH_SIZE);
  assign rd_busy     = state_q != IDLE;
  assign rd_valid    = cnt_q != 2'd0;
  assign rd_data     = fd_q[h_q];
  assign rd_last     = rd_valid && fl_q[h_q];
endmodule

// File: tb/tb_feature_tensor_buffer.sv
// tb_feature_tensor_buffer: self-checking bench with a tensor-level reference model
module tb_feature_tensor_buffer;
  localparam int G = 4, P = 16, D = 64, AW = 6, N = 4096;

  logic          clk = 1'b0, reset, in_valid, rd_start, rd_ready;
  logic [AW-1:0] in_addr;
  logic [P-1:0]  in_data, rd_data;
  logic          slice_done, frame_ready, rd_busy, rd_valid, rd_last, err_overrun;

  always #5 clk = ~clk;

  feature_tensor_buffer #(.GRAPH_SIZE(G), .PRECISION(P), .INPUT_DIM(D)) dut (
    .clk(clk), .reset(reset), .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid),
    .slice_done(slice_done), .frame_ready(frame_ready), .rd_start(rd_start), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .err_overrun(err_overrun)
  );

  typedef struct {int addr; int nodes; int beats; int sd; bit err;} vec_t;

  int checks = 0, failures = 0;
  logic [P-1:0] ref_mem [N];
  bit m_first, m_err;
  int m_last, m_cnt, m_nodes, m_slices, sd_seen;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_first = 1; m_err = 0; m_last = 0; m_cnt = 0; m_nodes = 0; m_slices = 0;
  endtask

  // one cycle of write traffic, predicted from the node/channel/slice rules
  task automatic cyc(input bit v, input int a, input logic [P-1:0] d);
    bit exp_sd, wr;
    int ch;
    exp_sd = 0; wr = 0; ch = 0;
    in_valid = v; in_addr = AW'(a); in_data = d;
    if (v) begin
      if (m_first || a != m_last) begin ch = 0; m_cnt = 1; m_last = a; m_first = 0; wr = 1; end
      else if (m_cnt == D) m_err = 1;
      else begin ch = m_cnt; m_cnt++; wr = 1; end
      if (wr) begin
        ref_mem[a*D+ch] = d;
        if (ch == D-1) begin
          m_nodes++;
          if (m_nodes % (G*G) == 0) begin exp_sd = 1; if (m_slices < G) m_slices++; end
        end
      end
    end
    tick();
    in_valid = 0;
    chk("slice_done", slice_done, exp_sd);
    chk("frame_ready", frame_ready, m_slices == G);
    chk("err_overrun", err_overrun, m_err);
    if (slice_done) sd_seen++;
  endtask

  task automatic node(input int a, input int beats, input bit pat, input bit gaps);
    for (int b = 0; b < beats; b++) begin
      if (gaps && $urandom_range(3) == 0) cyc(0, 0, '0);
      cyc(1, a, pat ? P'(a*D+b) : P'($urandom));
    end
  endtask

  task automatic readout(input bit throttle, input int stop_at);
    int k, n;
    bit stalled;
    logic [P-1:0] held;
    k = 0; n = 0; stalled = 0; held = '0;
    rd_start = 1;
    tick();
    rd_start = 0;
    chk("rd_valid_cycle1", rd_valid, 0);
    chk("rd_busy_cycle1", rd_busy, 1);
    tick();
    chk("rd_valid_cycle2", rd_valid, 1);
    while (k < N && n < 20000) begin
      if (k == stop_at) begin
        reset = 1; rd_ready = 0;
        tick();
        reset = 0;
        break;
      end
      rd_ready = throttle ? 1'($urandom_range(1)) : 1'b1;
      if (!throttle) chk("no_bubble", rd_valid, 1);
      if (stalled) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_hold", rd_data, held);
      end
      stalled = 0;
      if (rd_valid) begin
        if (rd_ready) begin
          chk("rd_data", rd_data, ref_mem[k]);
          chk("rd_last", rd_last, k == N-1);
          k++;
        end else begin
          held = rd_data; stalled = 1;
        end
      end
      n++;
      tick();
    end
    rd_ready = 0;
    if (stop_at < 0) begin
      chk("readout_words", k, N);
      chk("rd_busy_end", rd_busy, 0);
      chk("rd_valid_end", rd_valid, 0);
    end
  endtask

  initial begin
    tbl[0] = '{10, 1, 63, 0, 0};
    tbl[1] = '{11, 14, 64, 0, 0};
    tbl[2] = '{25, 1, 64, 0, 0};
    tbl[3] = '{26, 1, 64, 1, 0};
    tbl[4] = '{5, 1, 65, 0, 1};
    tbl[5] = '{6, 2, 64, 0, 1};
    reset = 1; in_valid = 0; in_addr = '0; in_data = '0; rd_start = 0; rd_ready = 0;
    model_reset();
    sd_seen = 0;
    tick();
    tick();
    chk("rst_slice_done", slice_done, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err", err_overrun, 0);
    reset = 0;
    rd_start = 1;
    tick();
    rd_start = 0;
    chk("early_start_busy", rd_busy, 0);
    tick();
    chk("early_start_busy2", rd_busy, 0);
    chk("early_start_valid", rd_valid, 0);
    for (int a = 0; a < G*G; a++) node(a, D, 1, 0);
    chk("one_slice_pulses", sd_seen, 1);
    chk("one_slice_frame", frame_ready, 0);
    chk("one_slice_err", err_overrun, 0);
    for (int a = G*G; a < G*G*G; a++) node(a, D, 1, 0);
    chk("frame_after_four", frame_ready, 1);
    readout(0, -1);
    for (int r = 0; r < 6; r++) begin
      sd_seen = 0;
      for (int n = 0; n < tbl[r].nodes; n++) node(tbl[r].addr + n, tbl[r].beats, 0, 1);
      chk("tbl_slice_pulses", sd_seen, tbl[r].sd);
      chk("tbl_err", err_overrun, tbl[r].err);
    end
    repeat (40) node($urandom_range(63), $urandom_range(3) == 0 ? $urandom_range(1, 63) : D, 0, 1);
    readout(1, -1);
    readout(0, 100);
    model_reset();
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_busy", rd_busy, 0);
    chk("midrst_frame_ready", frame_ready, 0);
    chk("midrst_err", err_overrun, 0);
    chk("midrst_rd_data", rd_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/feature_tensor_buffer.md
# feature_tensor_buffer

Collects the serialized node features produced by the feature-extractor output serializer into a complete GRAPH_SIZE³ × INPUT_DIM feature tensor. Each beat is one channel of one node. The block counts channels per node and nodes per time slice, and tracks when all GRAPH_SIZE time slices have been written. On request, it streams the whole tensor in flattened order over a valid/ready interface to the classifier head. It sits directly downstream of the serializer and upstream of the dense/classifier stage.

## Interface
- GRAPH_SIZE, 4, nodes per spatial/temporal axis
- PRECISION, graph_pkg::PRECISION, feature word width
- INPUT_DIM, 64, channels per node
- ADDR_WIDTH, $clog2(GRAPH_SIZE**3), node address width
- MEM_AW, ADDR_WIDTH+$clog2(INPUT_DIM), tensor memory address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_addr  in  ADDR_WIDTH  node address of the current beat
- in_data  in  PRECISION  channel value
- in_valid  in  1  beat valid; there is no backpressure
- slice_done  out  1  one-cycle pulse when GRAPH_SIZE² nodes have completed
- frame_ready  out  1  level; all GRAPH_SIZE slices written since reset
- rd_start  in  1  request a tensor readout
- rd_busy  out  1  readout in progress
- rd_data  out  PRECISION  tensor word
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_last  out  1  final word of the tensor, qualified by rd_valid
- err_overrun  out  1  sticky flag; more than INPUT_DIM beats arrived for one node

## Operation
- Memory: 1W1R, depth GRAPH_SIZE³·INPUT_DIM, 1-cycle registered read, read-first on an address collision.
- Write side. On in_valid:
  - If in_addr ≠ last_addr, or this is the first beat after reset: the channel index is 0, ch_cnt←1, last_addr←in_addr.
  - Otherwise the channel index is ch_cnt and ch_cnt increments.
  - Write address = in_addr·INPUT_DIM + channel index.
  - If ch_cnt == INPUT_DIM on a same-address beat: drop the beat, set err_overrun, leave ch_cnt unchanged.
- Node completion: a beat written at channel index INPUT_DIM-1 increments node_cnt (range 0..GRAPH_SIZE²-1).
- Slice completion: when node_cnt wraps from GRAPH_SIZE²-1 to 0, pulse slice_done. slices_cnt then increments, saturating at GRAPH_SIZE.
- frame_ready = (slices_cnt == GRAPH_SIZE). Once high, it stays high until reset; the window slides, so old slices are overwritten in place.
- Read FSM:
  - IDLE: rd_start && frame_ready → FILL, rd_ptr←0. rd_start is ignored while frame_ready=0 or while not in IDLE.
  - FILL / STREAM: a 2-entry output FIFO is prefetched from memory. A read is issued whenever (entries + in-flight) < 2 and rd_ptr has not reached its end. rd_ptr increments per issued read.
  - The state goes to STREAM once the first word has landed.
  - DRAIN: entered when all GRAPH_SIZE³·INPUT_DIM reads are issued. It returns to IDLE in the cycle after the beat with rd_last is accepted.
- rd_busy = (state ≠ IDLE).
- rd_data / rd_valid / rd_last are driven from the FIFO head. rd_data is held stable while rd_valid && !rd_ready.
- Writes are never blocked by reads. A readout reflects memory contents at the time each word is read.
- Reset mid-readout: the FIFO is flushed and the FSM goes to IDLE. The memory array is not cleared.

## Timing
- Reset values: slice_done=0, frame_ready=0, rd_busy=0, rd_valid=0, rd_last=0, rd_data=0, err_overrun=0. Internally: ch_cnt=0, node_cnt=0, slices_cnt=0, and the first-beat flag is set.
- Write: memory is updated at the clock edge ending the in_valid cycle. The data is readable from the next cycle.
- slice_done asserts in the cycle after the completing beat. frame_ready rises in that same cycle for the GRAPH_SIZE-th slice.
- Readout: rd_start is sampled in cycle 0, and rd_valid first asserts in cycle 2.
- With rd_ready held high, one word is transferred per cycle with no bubbles. The full tensor takes GRAPH_SIZE³·INPUT_DIM cycles after the first word.
- rd_busy deasserts in the cycle after the last handshake. A new rd_start is accepted from that cycle on.
- Stream order: node address ascending, channel ascending within each node. Index k = addr·INPUT_DIM + ch.

## Test plan
- Write one slice (GRAPH_SIZE=4: 16 nodes × 64 beats, data = addr·64+ch) → exactly one slice_done pulse, frame_ready stays 0, err_overrun stays 0.
- Write four slices, then pulse rd_start with rd_ready=1:
  - rd_valid appears 2 cycles later.
  - 4096 words are streamed in index order, each matching the written value mod 2^PRECISION.
  - rd_last is high only on word 4095.
  - rd_busy falls the next cycle.
- Random rd_ready throttling (about 50% duty) during a readout → no word lost or duplicated, rd_data stable while stalled, same 4096-word sequence.
- 65 consecutive beats to addr 5 → beat 65 is dropped, err_overrun=1, and memory at index 5·64+63 keeps the 64th value.
- A node that receives only 63 beats before the address changes → node_cnt does not advance, and the next node restarts at channel 0.
- rd_start pulsed before frame_ready → ignored, rd_busy stays 0. Separately, assert reset at word 100 of a readout → rd_valid=0 and rd_busy=0 in the next cycle, and frame_ready=0.
